// File: rtl/card_dealer.sv
// 52-card dealer: draws each card once, picking it with an LFSR probe and
// falling back to a linear scan so that every draw has bounded latency.
module card_dealer #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned MAX_TRIES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       deal_req,
  output logic       deal_ready,
  input  logic       shuffle_req,
  output logic       card_valid,
  output logic [5:0] card_index,
  output logic [3:0] card_rank,
  output logic [1:0] card_suit,
  output logic [3:0] card_points,
  output logic [5:0] cards_left,
  output logic       deck_empty,
  output logic       busy
);

  localparam logic [15:0] SEED_EFF   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [7:0]  TRIES_LAST = 8'(MAX_TRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PROBE = 3'd1,
    S_SCAN  = 3'd2,
    S_EMIT  = 3'd3,
    S_SHUF  = 3'd4
  } state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic [15:0] n;
    n = {1'b0, v[15:1]};
    if (v[0]) begin
      n = n ^ 16'hB400;
    end else begin
      n = n;
    end
    return n;
  endfunction

  function automatic logic [1:0] suit_of(input logic [5:0] i);
    logic [1:0] s;
    if (i >= 6'd39) begin
      s = 2'd3;
    end else if (i >= 6'd26) begin
      s = 2'd2;
    end else if (i >= 6'd13) begin
      s = 2'd1;
    end else begin
      s = 2'd0;
    end
    return s;
  endfunction

  function automatic logic [3:0] rank_of(input logic [5:0] i, input logic [1:0] s);
    logic [5:0] r;
    r = i - (6'd13 * {4'd0, s}) + 6'd1;
    return r[3:0];
  endfunction

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [51:0] used_q, used_d;
  logic [5:0]  left_q, left_d;
  logic [7:0]  tries_q, tries_d;
  logic [5:0]  ptr_q, ptr_d;
  logic [5:0]  idx_q, idx_d;
  logic        valid_q, ready_q, empty_q, busy_q;
  logic [5:0]  index_q;
  logic [3:0]  rank_q, points_q;
  logic [1:0]  suit_q;

  logic [5:0]  cand_s;
  logic [63:0] used_pad_s;
  logic [1:0]  suit_s;
  logic [3:0]  rank_s, points_s;

  // Candidate lookup: indices 52..63 do not exist and read as already used.
  always_comb begin
    cand_s     = lfsr_q[5:0];
    used_pad_s = {12'hFFF, used_q};
    lfsr_d     = lfsr_next(lfsr_q);
  end

  // Draw / shuffle FSM next-state logic.
  always_comb begin
    state_d = state_q;
    used_d  = used_q;
    left_d  = left_q;
    tries_d = tries_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (shuffle_req) begin
          state_d = S_SHUF;
          used_d  = 52'd0;
          left_d  = 6'd52;
        end else if (deal_req && (left_q != 6'd0)) begin
          state_d = S_PROBE;
          tries_d = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PROBE: begin
        if (!used_pad_s[cand_s]) begin
          idx_d   = cand_s;
          state_d = S_EMIT;
        end else if (tries_q == TRIES_LAST) begin
          ptr_d   = (cand_s >= 6'd52) ? (cand_s - 6'd52) : cand_s;
          state_d = S_SCAN;
        end else begin
          tries_d = tries_q + 8'd1;
        end
      end
      S_SCAN: begin
        if (!used_pad_s[ptr_q]) begin
          idx_d   = ptr_q;
          state_d = S_EMIT;
        end else begin
          ptr_d = (ptr_q == 6'd51) ? 6'd0 : (ptr_q + 6'd1);
        end
      end
      S_EMIT: begin
        used_d  = used_q | (52'd1 << idx_q);
        left_d  = left_q - 6'd1;
        state_d = S_IDLE;
      end
      S_SHUF: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Card field decode of the index about to be emitted.
  always_comb begin
    suit_s   = suit_of(idx_d);
    rank_s   = rank_of(idx_d, suit_s);
    points_s = (rank_s > 4'd10) ? 4'd10 : rank_s;
  end

  // State, deck bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED_EFF;
      used_q   <= 52'd0;
      left_q   <= 6'd52;
      tries_q  <= 8'd0;
      ptr_q    <= 6'd0;
      idx_q    <= 6'd0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      empty_q  <= 1'b0;
      busy_q   <= 1'b0;
      index_q  <= 6'd0;
      rank_q   <= 4'd0;
      suit_q   <= 2'd0;
      points_q <= 4'd0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      used_q  <= used_d;
      left_q  <= left_d;
      tries_q <= tries_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      valid_q <= (state_d == S_EMIT);
      ready_q <= (state_d == S_IDLE) && (left_d != 6'd0);
      empty_q <= (left_d == 6'd0);
      busy_q  <= (state_d != S_IDLE);
      // Card fields only change when a new card is emitted.
      if (state_d == S_EMIT) begin
        index_q  <= idx_d;
        rank_q   <= rank_s;
        suit_q   <= suit_s;
        points_q <= points_s;
      end else begin
        index_q  <= index_q;
        rank_q   <= rank_q;
        suit_q   <= suit_q;
        points_q <= points_q;
      end
    end
  end

  assign deal_ready  = ready_q;
  assign card_valid  = valid_q;
  assign card_index  = index_q;
  assign card_rank   = rank_q;
  assign card_suit   = suit_q;
  assign card_points = points_q;
  assign cards_left  = left_q;
  assign deck_empty  = empty_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: a deck model (array + seed-driven probe sequence)
// predicts every dealt index and its latency for two parameterisations.
module tb_card_dealer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic deal_req = 1'b0;
  logic shuffle_req = 1'b0;
  logic sel = 1'b0;

  logic       a_req, a_ready, a_valid, a_empty, a_busy;
  logic [5:0] a_index, a_left;
  logic [3:0] a_rank, a_points;
  logic [1:0] a_suit;
  logic       b_req, b_ready, b_valid, b_empty, b_busy;
  logic [5:0] b_index, b_left;
  logic [3:0] b_rank, b_points;
  logic [1:0] b_suit;

  logic       v_ready, v_valid, v_empty, v_busy;
  logic [5:0] v_index, v_left;
  logic [3:0] v_rank, v_points;
  logic [1:0] v_suit;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] m_lfsr_a, m_lfsr_b;
  logic        m_used [52];
  int          m_left;
  logic [51:0] seen;
  int          exp_first;

  always #5 clk = ~clk;

  assign a_req = deal_req & ~sel;
  assign b_req = deal_req & sel;

  card_dealer u_a (
    .clk(clk), .reset(reset), .deal_req(a_req), .deal_ready(a_ready),
    .shuffle_req(shuffle_req), .card_valid(a_valid), .card_index(a_index),
    .card_rank(a_rank), .card_suit(a_suit), .card_points(a_points),
    .cards_left(a_left), .deck_empty(a_empty), .busy(a_busy)
  );

  card_dealer #(.LFSR_SEED(16'h0000), .MAX_TRIES(1)) u_b (
    .clk(clk), .reset(reset), .deal_req(b_req), .deal_ready(b_ready),
    .shuffle_req(shuffle_req), .card_valid(b_valid), .card_index(b_index),
    .card_rank(b_rank), .card_suit(b_suit), .card_points(b_points),
    .cards_left(b_left), .deck_empty(b_empty), .busy(b_busy)
  );

  assign v_ready  = sel ? b_ready  : a_ready;
  assign v_valid  = sel ? b_valid  : a_valid;
  assign v_empty  = sel ? b_empty  : a_empty;
  assign v_busy   = sel ? b_busy   : a_busy;
  assign v_index  = sel ? b_index  : a_index;
  assign v_left   = sel ? b_left   : a_left;
  assign v_rank   = sel ? b_rank   : a_rank;
  assign v_points = sel ? b_points : a_points;
  assign v_suit   = sel ? b_suit   : a_suit;

  // Polynomial x^16+x^14+x^13+x^11+1 in right-shifting Galois form.
  function automatic logic [15:0] poly_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // Seed 0 is modelled as seed 1 for the second instance.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_lfsr_a <= 16'hACE1;
      m_lfsr_b <= 16'h0001;
    end else begin
      m_lfsr_a <= poly_step(m_lfsr_a);
      m_lfsr_b <= poly_step(m_lfsr_b);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 52; i++) m_used[i] = 1'b0;
    m_left = 52;
  endtask

  // Given the LFSR value in the first probe cycle, work out which card is drawn
  // and how many cycles after the accept cycle card_valid appears.
  task automatic predict(input logic [15:0] l0, input int mt, output int idx, output int lat);
    logic [15:0] v;
    int cand, ptr;
    v = l0; ptr = 0; idx = -1; lat = -1;
    for (int t = 0; t < mt; t++) begin
      cand = int'(v[5:0]);
      if (cand < 52 && !m_used[cand]) begin
        idx = cand; lat = t + 2;
        return;
      end
      ptr = cand % 52;
      v = poly_step(v);
    end
    for (int s = 0; s < 52; s++) begin
      if (!m_used[(ptr + s) % 52]) begin
        idx = (ptr + s) % 52; lat = mt + s + 2;
        return;
      end
    end
  endtask

  // Called at a falling edge; deals one card after `gap` idle cycles.
  task automatic deal_one(input int gap, output int obs_idx, output int obs_lat, output int exp_idx);
    int k, cyc, elat, rank;
    repeat (gap) @(negedge clk);
    deal_req = 1'b1;
    k = 0;
    while (!v_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("deal_ready_before_accept", v_ready, 1);
    predict(poly_step(sel ? m_lfsr_b : m_lfsr_a), sel ? 1 : 8, exp_idx, elat);
    @(negedge clk);
    deal_req = 1'b0;
    cyc = 1;
    while (!v_valid && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    obs_idx = int'(v_index);
    obs_lat = cyc;
    rank = exp_idx % 13 + 1;
    chk("latency", cyc, elat);
    chk("card_index", v_index, exp_idx);
    chk("card_suit", v_suit, exp_idx / 13);
    chk("card_rank", v_rank, rank);
    chk("card_points", v_points, (rank > 10) ? 10 : rank);
    chk("cards_left_during_emit", v_left, m_left);
    if (exp_idx >= 0) m_used[exp_idx] = 1'b1;
    m_left--;
    @(negedge clk);
    chk("valid_one_cycle", v_valid, 0);
    chk("cards_left_after", v_left, m_left);
    chk("deck_empty_after", v_empty, (m_left == 0) ? 1 : 0);
    chk("deal_ready_after", v_ready, (m_left != 0) ? 1 : 0);
  endtask

  initial begin
    int oi, ol, ei, rem;
    model_reset();
    seen = '0;

    // Power-on reset values.
    repeat (3) @(negedge clk);
    chk("rst_valid", a_valid, 0);
    chk("rst_index", a_index, 0);
    chk("rst_rank", a_rank, 0);
    chk("rst_suit", a_suit, 0);
    chk("rst_points", a_points, 0);
    chk("rst_left", a_left, 52);
    chk("rst_empty", a_empty, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_ready", a_ready, 1);
    reset = 1'b1;

    // Full deck with randomized gaps.
    deal_one(0, oi, ol, ei);
    exp_first = ei;
    seen[oi] = 1'b1;
    for (int n = 1; n < 52; n++) begin
      deal_one($urandom_range(0, 3), oi, ol, ei);
      if (oi >= 0 && oi < 52) seen[oi] = 1'b1;
    end
    chk("all_indices_distinct", $countones(seen), 52);
    chk("empty_left", a_left, 0);

    // Held request on an empty deck is not accepted.
    deal_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("empty_hold_ready", a_ready, 0);
      chk("empty_hold_empty", a_empty, 1);
      chk("empty_hold_valid", a_valid, 0);
    end
    shuffle_req = 1'b1;
    @(negedge clk);
    shuffle_req = 1'b0;
    model_reset();
    chk("shuf_left", a_left, 52);
    chk("shuf_empty", a_empty, 0);
    chk("shuf_busy", a_busy, 1);
    @(negedge clk);
    chk("post_shuf_ready", a_ready, 1);
    deal_one(0, oi, ol, ei);

    // Shuffle beats a simultaneous deal request.
    for (int n = 1; n < 10; n++) deal_one($urandom_range(0, 3), oi, ol, ei);
    deal_req = 1'b1;
    shuffle_req = 1'b1;
    @(negedge clk);
    shuffle_req = 1'b0;
    model_reset();
    chk("tie_busy", a_busy, 1);
    chk("tie_left", a_left, 52);
    chk("tie_valid", a_valid, 0);
    @(negedge clk);
    chk("tie_valid_idle", a_valid, 0);
    chk("tie_ready_after_shuf", a_ready, 1);
    deal_one(0, oi, ol, ei);

    // Reset while probing aborts the draw and restarts the seed sequence.
    deal_req = 1'b1;
    @(negedge clk);
    chk("probe_busy", a_busy, 1);
    deal_req = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", a_valid, 0);
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_left", a_left, 52);
    chk("mid_rst_empty", a_empty, 0);
    chk("mid_rst_index", a_index, 0);
    chk("mid_rst_rank", a_rank, 0);
    chk("mid_rst_points", a_points, 0);
    @(negedge clk);
    chk("mid_rst_no_valid", a_valid, 0);
    reset = 1'b1;
    model_reset();
    deal_one(0, oi, ol, ei);
    chk("same_first_index", oi, exp_first);

    // Seed 0 (modelled as seed 1) with a single probe per draw.
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    sel = 1'b1;
    model_reset();
    for (int n = 0; n < 51; n++) deal_one($urandom_range(0, 3), oi, ol, ei);
    rem = -1;
    for (int i = 0; i < 52; i++) if (!m_used[i]) rem = i;
    deal_one($urandom_range(0, 3), oi, ol, ei);
    chk("last_card_is_remaining", oi, rem);
    chk("last_card_latency_bound", (ol <= 54) ? 1 : 0, 1);
    chk("b_deck_empty", b_empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Upstream card source for blackjackGame. It holds one 52-card deck and deals each card without replacement when the game FSM asks for one.
- Selection is pseudo-random, using a free-running LFSR with rejection sampling. A bounded linear-scan fallback guarantees worst-case latency.
- Reports cards remaining, deck-empty status and handles reshuffle requests. The game FSM consumes card_rank/card_points on card_valid.

Parameters:
- LFSR_SEED, 16'hACE1, reset value of LFSR. A value of 0 is replaced by 16'h0001.
- MAX_TRIES, 8, failed random probes allowed per draw before switching to linear scan (1..255).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- deal_req  input  1  request one card; held until accepted
- deal_ready  output  1  high when a deal_req will be accepted this cycle
- shuffle_req  input  1  return all 52 cards to the deck
- card_valid  output  1  one-cycle pulse; card outputs valid
- card_index  output  6  dealt card index, 0..51
- card_rank  output  4  1=A, 2..10, 11=J, 12=Q, 13=K
- card_suit  output  2  index/13
- card_points  output  4  A=1, 2..10 face value, J/Q/K=10
- cards_left  output  6  undealt cards, 0..52
- deck_empty  output  1  cards_left==0
- busy  output  1  state != IDLE

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE; used bitmap[51:0]=0; cards_left=52; lfsr=LFSR_SEED (0 becomes 1).
  - card_valid=0; card_index/rank/suit/points=0; deck_empty=0; busy=0.
  - Reset mid-draw aborts the draw: no card is marked used and no card_valid is issued.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11+1.
  - Advances every cycle while out of reset, independent of state. It never reaches 0.
- Handshake:
  - deal_ready = (state==IDLE) && cards_left!=0.
  - Accept when deal_req && deal_ready && !shuffle_req.
  - deal_req while deal_ready==0 is held off. It is neither lost nor queued beyond the level of the input.
- Shuffle:
  - Sampled only in IDLE, and has priority over deal_req in the same cycle.
  - Next cycle: bitmap=0, cards_left=52, deck_empty=0. shuffle takes 1 cycle, with busy=1 for that cycle (state SHUF).
  - shuffle_req during PROBE/SCAN is ignored until IDLE. If still held, it takes effect then.
- FSM: IDLE, PROBE, SCAN, EMIT, SHUF.
  - IDLE -> PROBE on accept, with tries=0.
  - IDLE -> SHUF on shuffle_req.
  - PROBE, each cycle:
    - cand = lfsr[5:0].
    - If cand<52 and !used[cand]: latch cand and go to EMIT.
    - Else tries++. When tries==MAX_TRIES, go to SCAN with ptr=cand mod 52 (cand>=52: subtract 52).
  - SCAN, each cycle:
    - If !used[ptr]: latch ptr and go to EMIT.
    - Else ptr = (ptr==51) ? 0 : ptr+1.
    - At least one card is free on entry, so this terminates within 52 cycles.
  - EMIT, one cycle:
    - used[idx]=1; cards_left--.
    - card_valid=1 with registered card_index=idx, card_suit=idx/13, card_rank=idx%13+1, card_points=min(rank,10).
    - Then IDLE.
  - SHUF -> IDLE.
- Card outputs hold their last value until the next EMIT. card_valid is high only in the EMIT cycle.
- Latency, accept to card_valid:
  - Minimum 2 cycles.
  - Maximum MAX_TRIES+52+1 cycles.
- deck_empty rises in the cycle after the EMIT of the 52nd card. deal_ready falls at the same time.

Test Plan:
- Reset, then deal 52 cards, one deal_req each:
  - 52 card_valid pulses.
  - All card_index distinct, covering 0..51.
  - cards_left decrements 52→0.
  - Every card has rank in 1..13 and points=min(rank,10).
- With the deck empty, hold deal_req for 20 cycles:
  - deal_ready=0, deck_empty=1, no card_valid.
  - Then pulse shuffle_req: one cycle later cards_left=52, deck_empty=0, deal_ready=1, and the held deal_req is then accepted.
- Assert shuffle_req and deal_req in the same IDLE cycle after 10 deals:
  - Shuffle wins: cards_left=52, and no card_valid in that window.
  - The deal is accepted the cycle after SHUF.
- MAX_TRIES=1, 51 cards dealt:
  - The last deal reaches SCAN, returns the single remaining index and issues card_valid within 54 cycles of accept.
- Assert reset for 1 cycle while busy in PROBE:
  - All outputs at reset values, cards_left=52, no card_valid.
  - The first post-reset deal yields the same index as the first deal after power-on reset (same seed).
- LFSR_SEED=0:
  - The block behaves identically to seed 16'h0001.
  - No lockup: card_valid still follows within the latency bound.
